// File: rtl/mem_port_scheduler.sv
// Single data-memory port sequencer: arbitrates three load slots against a FIFO of
// committed stores, runs the memory handshake and the CDB writeback for loads.
module mem_port_scheduler #(
   parameter int SQ_DEPTH = 4,
   parameter int CNT_W    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       ld_ready,
   input  logic [191:0]     ld_addr,
   input  logic             st_push,
   input  logic [63:0]      st_addr,
   input  logic [63:0]      st_data,
   output logic             st_full,
   output logic [CNT_W-1:0] st_count,
   output logic             mem_req,
   output logic             mem_we,
   output logic [63:0]      mem_addr,
   output logic [63:0]      mem_wdata,
   input  logic             mem_ready,
   input  logic [63:0]      mem_rdata,
   output logic             cdb_req,
   input  logic             cdb_grant,
   output logic [3:0]       cdb_id,
   output logic [63:0]      cdb_data,
   output logic [2:0]       ld_remove
);
   localparam int PTR_W = $clog2(SQ_DEPTH);

   typedef enum logic [1:0] {IDLE, LD_MEM, LD_CDB, ST_MEM} state_t;

   state_t           state_q;
   logic [63:0]      sq_addr_q [SQ_DEPTH];
   logic [63:0]      sq_data_q [SQ_DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       rr_q, slot_q;
   logic             mem_req_q, mem_we_q, cdb_req_q;
   logic [63:0]      mem_addr_q, mem_wdata_q, cdb_data_q;
   logic [3:0]       cdb_id_q;
   logic [2:0]       ld_remove_q;

   logic [SQ_DEPTH-1:0] sq_valid;
   logic [2:0]          ld_hit, ld_elig;
   logic                ld_found;
   logic [1:0]          ld_pick;
   logic                push_ok, pop, full;

   function automatic logic [1:0] wrap3(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

   assign full    = (count_q == CNT_W'(SQ_DEPTH));
   assign push_ok = st_push && !full;
   assign pop     = (state_q == ST_MEM) && mem_ready;
   assign count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);

   // An entry is live when its distance from the head is below the occupancy.
   genvar gi;
   for (gi = 0; gi < SQ_DEPTH; gi++) begin : g_valid
      logic [PTR_W-1:0] offs;
      assign offs         = PTR_W'(gi) - head_q;
      assign sq_valid[gi] = (CNT_W'(offs) < count_q);
   end

   always_comb begin
      ld_hit = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < SQ_DEPTH; j++) begin
            if (sq_valid[j] && (sq_addr_q[j] == ld_addr[64*i +: 64])) ld_hit[i] = 1'b1;
         end
      end
   end

   assign ld_elig = ld_ready & ~ld_hit;

   // Walk candidates from farthest to nearest so the one closest to rr_q wins.
   always_comb begin
      ld_found = 1'b0;
      ld_pick  = rr_q;
      for (int k = 2; k >= 0; k--) begin
         if (ld_elig[wrap3({1'b0, rr_q} + 3'(k))]) begin
            ld_found = 1'b1;
            ld_pick  = wrap3({1'b0, rr_q} + 3'(k));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         sq_addr_q[tail_q] <= st_addr;
         sq_data_q[tail_q] <= st_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         rr_q        <= '0;
         slot_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cdb_req_q   <= 1'b0;
         cdb_id_q    <= '0;
         cdb_data_q  <= '0;
         ld_remove_q <= '0;
      end else begin
         ld_remove_q <= '0;
         count_q     <= count_d;
         if (push_ok) tail_q <= tail_q + 1'b1;
         if (pop)     head_q <= head_q + 1'b1;
         case (state_q)
            IDLE: begin
               if (full || (!ld_found && count_q != '0)) begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= sq_addr_q[head_q];
                  mem_wdata_q <= sq_data_q[head_q];
                  state_q     <= ST_MEM;
               end else if (ld_found) begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= ld_addr[64*ld_pick +: 64];
                  mem_wdata_q <= '0;
                  slot_q      <= ld_pick;
                  state_q     <= LD_MEM;
               end
            end
            LD_MEM: begin
               if (mem_ready) begin
                  mem_req_q  <= 1'b0;
                  cdb_req_q  <= 1'b1;
                  cdb_id_q   <= 4'd6 + {2'b00, slot_q};
                  cdb_data_q <= mem_rdata;
                  state_q    <= LD_CDB;
               end
            end
            LD_CDB: begin
               if (cdb_grant) begin
                  cdb_req_q           <= 1'b0;
                  cdb_id_q            <= '0;
                  cdb_data_q          <= '0;
                  ld_remove_q[slot_q] <= 1'b1;
                  rr_q                <= (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
                  state_q             <= IDLE;
               end
            end
            ST_MEM: begin
               if (mem_ready) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign st_full   = full;
   assign st_count  = count_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cdb_req   = cdb_req_q;
   assign cdb_id    = cdb_id_q;
   assign cdb_data  = cdb_data_q;
   assign ld_remove = ld_remove_q;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler: reset, load path, round-robin, store
// priority, address hazard, full-drop and mid-operation reset.
module tb_mem_port_scheduler;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   ld_ready;
   logic [191:0] ld_addr;
   logic         st_push;
   logic [63:0]  st_addr, st_data;
   logic         st_full;
   logic [2:0]   st_count;
   logic         mem_req, mem_we;
   logic [63:0]  mem_addr, mem_wdata;
   logic         mem_ready;
   logic [63:0]  mem_rdata;
   logic         cdb_req, cdb_grant;
   logic [3:0]   cdb_id;
   logic [63:0]  cdb_data;
   logic [2:0]   ld_remove;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_scheduler #(.SQ_DEPTH(4), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .ld_ready(ld_ready), .ld_addr(ld_addr),
      .st_push(st_push), .st_addr(st_addr), .st_data(st_data),
      .st_full(st_full), .st_count(st_count),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_id(cdb_id), .cdb_data(cdb_data),
      .ld_remove(ld_remove)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("txn %s = %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      ld_ready  = '0;
      ld_addr   = '0;
      st_push   = 1'b0;
      st_addr   = '0;
      st_data   = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      cdb_grant = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic push(input logic [63:0] a, input logic [63:0] d);
      st_push = 1'b1;
      st_addr = a;
      st_data = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ids [4];
      int n;

      // Reset then idle
      do_reset();
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_cdb_req", cdb_req, 0);
      check("rst_cdb_id", cdb_id, 0);
      check("rst_st_count", st_count, 0);
      check("rst_st_full", st_full, 0);
      check("rst_ld_remove", ld_remove, 0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      check("idle_rdy_mem_req", mem_req, 0);
      check("idle_rdy_cdb_req", cdb_req, 0);
      check("idle_rdy_count", st_count, 0);

      // Single load on slot 1 (cycle 0 = now)
      ld_ready = 3'b010;
      ld_addr[64 +: 64] = 64'h40;
      tick();                                    // cycle 1
      check("ld_c1_mem_req", mem_req, 1);
      check("ld_c1_mem_addr", mem_addr, 64'h40);
      check("ld_c1_mem_we", mem_we, 0);
      tick();                                    // cycle 2
      check("ld_c2_mem_req", mem_req, 1);
      tick();                                    // cycle 3
      check("ld_c3_mem_req", mem_req, 1);
      mem_ready = 1'b1;
      mem_rdata = 64'hDEAD;
      tick();                                    // cycle 4
      mem_ready = 1'b0;
      check("ld_c4_mem_req", mem_req, 0);
      check("ld_c4_cdb_req", cdb_req, 1);
      check("ld_c4_cdb_id", cdb_id, 7);
      check("ld_c4_cdb_data", cdb_data, 64'hDEAD);
      check("ld_c4_remove", ld_remove, 0);
      cdb_grant = 1'b1;
      tick();                                    // cycle 5
      cdb_grant = 1'b0;
      ld_ready  = 3'b000;
      check("ld_c5_remove", ld_remove, 3'b010);
      check("ld_c5_cdb_req", cdb_req, 0);
      check("ld_c5_cdb_id", cdb_id, 0);
      tick();
      check("ld_c6_remove", ld_remove, 0);

      // Round-robin fairness with immediate completion
      do_reset();
      ld_ready  = 3'b111;
      ld_addr   = {64'h3000, 64'h2000, 64'h1000};
      mem_ready = 1'b1;
      mem_rdata = 64'h99;
      cdb_grant = 1'b1;
      n = 0;
      for (int c = 0; c < 30 && n < 4; c++) begin
         tick();
         if (cdb_req) begin
            ids[n] = cdb_id;
            n++;
         end
      end
      check("rr_count", n, 4);
      if (n == 4) begin
         check("rr_id0", ids[0], 6);
         check("rr_id1", ids[1], 7);
         check("rr_id2", ids[2], 8);
         check("rr_id3", ids[3], 6);
      end

      // Store priority when full, full drop, then mid-operation reset
      do_reset();
      ld_ready = 3'b100;
      ld_addr[128 +: 64] = 64'h900;
      tick();                                    // cycle 1: load on slot 2 holds the port
      check("sp_ld_busy", mem_req, 1);
      push(64'h100, 64'h11);
      tick();
      push(64'h200, 64'h22);
      tick();
      push(64'h300, 64'h33);
      tick();
      push(64'h400, 64'h44);
      tick();                                    // cycle 5
      check("sp_full", st_full, 1);
      check("sp_count4", st_count, 4);
      push(64'h500, 64'h55);
      tick();                                    // cycle 6
      st_push = 1'b0;
      check("drop_count", st_count, 4);
      mem_ready = 1'b1;
      mem_rdata = 64'h77;
      ld_ready  = 3'b101;
      ld_addr[0 +: 64] = 64'h10;
      tick();                                    // cycle 7
      mem_ready = 1'b0;
      check("sp_cdb_id", cdb_id, 8);
      check("sp_cdb_data", cdb_data, 64'h77);
      cdb_grant = 1'b1;
      tick();                                    // cycle 8
      cdb_grant = 1'b0;
      ld_ready  = 3'b001;
      check("sp_remove", ld_remove, 3'b100);
      tick();                                    // cycle 9
      check("sp_st_req", mem_req, 1);
      check("sp_st_we", mem_we, 1);
      check("sp_st_addr", mem_addr, 64'h100);
      check("sp_st_wdata", mem_wdata, 64'h11);
      mem_ready = 1'b1;
      tick();                                    // cycle 10
      mem_ready = 1'b0;
      check("sp_pop_count", st_count, 3);
      tick();                                    // cycle 11
      check("sp_ld_we", mem_we, 0);
      check("sp_ld_addr", mem_addr, 64'h10);
      mem_ready = 1'b1;
      mem_rdata = 64'hAB;
      tick();                                    // cycle 12: LD_CDB
      mem_ready = 1'b0;
      check("mr_cdb_req", cdb_req, 1);
      rst_n = 1'b0;
      tick();
      rst_n    = 1'b1;
      ld_ready = 3'b000;
      check("mr_cdb_req_low", cdb_req, 0);
      check("mr_remove", ld_remove, 0);
      check("mr_count", st_count, 0);
      tick();
      check("mr_remove_after", ld_remove, 0);

      // Address hazard and simultaneous push/pop
      do_reset();
      push(64'h80, 64'h5);
      tick();                                    // cycle 1
      st_push  = 1'b0;
      ld_ready = 3'b001;
      ld_addr[0 +: 64] = 64'h80;
      tick();                                    // cycle 2
      check("hz_st_we", mem_we, 1);
      check("hz_st_addr", mem_addr, 64'h80);
      check("hz_st_wdata", mem_wdata, 64'h5);
      push(64'h90, 64'h6);
      tick();                                    // cycle 3
      check("hz_still_st", mem_we, 1);
      push(64'hA0, 64'h7);
      mem_ready = 1'b1;
      tick();                                    // cycle 4
      st_push   = 1'b0;
      mem_ready = 1'b0;
      check("hz_pushpop_count", st_count, 2);
      check("hz_idle_gap", mem_req, 0);
      tick();                                    // cycle 5
      check("hz_ld_req", mem_req, 1);
      check("hz_ld_we", mem_we, 0);
      check("hz_ld_addr", mem_addr, 64'h80);
      mem_ready = 1'b1;
      mem_rdata = 64'h5;
      tick();                                    // cycle 6
      mem_ready = 1'b0;
      check("hz_cdb_id", cdb_id, 6);
      cdb_grant = 1'b1;
      tick();                                    // cycle 7
      cdb_grant = 1'b0;
      ld_ready  = 3'b000;
      check("hz_remove", ld_remove, 3'b001);
      tick();                                    // cycle 8
      check("hz_fifo_addr", mem_addr, 64'h90);
      check("hz_fifo_wdata", mem_wdata, 64'h6);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_scheduler.md
Name: mem_port_scheduler

Overview:
- Sequences the single data-memory port between the three load reservation slots (tags ld_1=6, ld_2=7, ld_3=8) and committed stores from the ROB.
- Buffers committed stores in a small FIFO and picks one memory operation at a time.
- Drives the memory request handshake, then requests the CDB to write back load results.
- Pulses per-slot remove signals so load slots are freed only after CDB grant.

Parameters:
- SQ_DEPTH, 4, committed-store queue depth; power of two, at least 2.
- CNT_W, 3, store-count width; equals log2(SQ_DEPTH)+1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- ld_ready  in  3  bit i = load slot i (tag 6+i) has a computed address
- ld_addr  in  192  slot i address at [64i+63:64i]
- st_push  in  1  ROB commits a store this cycle
- st_addr  in  64  committed store address
- st_data  in  64  committed store value
- st_full  out  1  store queue holds SQ_DEPTH entries
- st_count  out  CNT_W  valid store-queue entries
- mem_req  out  1  memory operation active
- mem_we  out  1  1=store, 0=load
- mem_addr  out  64  memory address
- mem_wdata  out  64  store data
- mem_ready  in  1  one-cycle completion pulse from memory
- mem_rdata  in  64  load data, valid with mem_ready
- cdb_req  out  1  request to CDB arbiter
- cdb_grant  in  1  CDB arbiter grant
- cdb_id  out  4  writeback tag (6..8); 0 (notag) when idle
- cdb_data  out  64  load result
- ld_remove  out  3  one-hot, one-cycle pulse that frees load slot i

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE; store queue is emptied; round-robin pointer goes to slot 0.
  - All outputs are 0, including cdb_id=0.
  - Reset mid-operation abandons the operation; mem_req and cdb_req are low after that edge.
- Store queue:
  - FIFO with head/tail pointers that wrap modulo SQ_DEPTH.
  - st_push with st_full=1 is dropped, even if a pop occurs in the same cycle.
  - st_full and st_count reflect registered state.
- States: IDLE, LD_MEM, LD_CDB, ST_MEM.
- Selection in IDLE, evaluated every cycle; the first matching rule wins:
  - (a) st_count==SQ_DEPTH: go to ST_MEM with the queue head.
  - (b) An eligible load exists: go to LD_MEM. A load is eligible when ld_ready[i]=1 and ld_addr[i] matches no valid store-queue entry (full 64-bit compare). Search order starts at the round-robin pointer and wraps 0->1->2->0.
  - (c) Queue non-empty: go to ST_MEM.
  - (d) Otherwise stay in IDLE.
- On leaving IDLE, register the following and hold them stable until the operation completes:
  - mem_addr and mem_wdata
  - mem_we (1 for stores, 0 for loads)
  - the selected slot/tag
- LD_MEM:
  - mem_req=1, mem_we=0.
  - On mem_ready, latch mem_rdata into cdb_data, set cdb_id=6+slot, and go to LD_CDB.
- LD_CDB:
  - cdb_req=1; cdb_id and cdb_data are held.
  - On cdb_grant: ld_remove[slot] pulses on the next cycle; round-robin pointer = slot+1 mod 3; go to IDLE.
  - cdb_req drops the cycle after the grant.
- ST_MEM:
  - mem_req=1, mem_we=1.
  - On mem_ready: pop the queue head, go to IDLE.
  - A push in the same cycle is still accepted if st_full was 0.
- Latency:
  - At least one IDLE cycle separates operations.
  - Load: select at cycle 0, mem_req from cycle 1. mem_ready at cycle k gives cdb_req at k+1. Grant at k+1 gives ld_remove at k+2.
- Boundary and misuse rules:
  - mem_ready outside LD_MEM/ST_MEM is ignored.
  - cdb_grant outside LD_CDB is ignored.
  - ld_ready[slot] falling mid-operation is ignored and the operation completes; the slot must hold its value until removed.
  - A load whose address matches a queued store waits until that store drains.
  - Simultaneous push and pop leaves st_count unchanged.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 for 2 cycles, then 1.
  - Required: all outputs 0, st_count=0.
  - Stimulus: assert mem_ready while idle.
  - Required: no state change.
- Single load:
  - Stimulus: ld_ready=3'b010, ld_addr slot1=0x40; mem_ready with rdata=0xDEAD at cycle 3; cdb_grant at cycle 4.
  - Required: mem_req cycles 1-3, mem_addr=0x40, mem_we=0; cdb_req at cycle 4 with cdb_id=7, cdb_data=0xDEAD; ld_remove=3'b010 at cycle 5.
- Round-robin fairness:
  - Stimulus: all three slots ready continuously, immediate mem_ready and grant.
  - Required: cdb_id sequence 6, 7, 8, 6.
- Store priority when full:
  - Stimulus: push 4 stores (0x100..0x400) while loads are stalled.
  - Required: st_full=1; next op is mem_we=1, addr=0x100, even with ld_ready=3'b001 asserted.
- Address hazard:
  - Stimulus: queue store to 0x80 (data 0x5); ld_ready slot0 with addr 0x80.
  - Required: the store issues first; the load issues only after the store's mem_ready.
- Full drop and mid-op reset:
  - Stimulus: st_push while full.
  - Required: st_count stays 4.
  - Stimulus: rst_n=0 during LD_CDB.
  - Required: cdb_req=0 next cycle, no ld_remove pulse.
